// File: rtl/ahb_sram_bridge.sv
// AHB-Lite slave to single-port synchronous SRAM bridge.
//
// Word reads take one wait state. Word writes take none. Byte and halfword
// writes are done as read-modify-write, so the SRAM only ever sees full-word
// writes (SRAM_BE is always 4'hF while SRAM_WE=1).
//
// Ports:
//   CLK, RST         clock, synchronous active-high reset
//   HSEL..HREADY     AHB-Lite slave inputs (only HADDR[AW+1:0] is decoded)
//   HREADYOUT        slave ready, HRDATA read data, HRESP always OKAY
//   SRAM_CSN/WE/BE   SRAM control (chip select is active low)
//   SRAM_ADDR/DI     SRAM word address and write data
//   SRAM_DO          SRAM read data, valid the cycle after a read is issued
module ahb_sram_bridge #(
  parameter int unsigned AW = 12
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic [31:0]   HRDATA,
  output logic          HRESP,
  output logic          SRAM_CSN,
  output logic [AW-1:0] SRAM_ADDR,
  output logic          SRAM_WE,
  output logic [3:0]    SRAM_BE,
  output logic [31:0]   SRAM_DI,
  input  logic [31:0]   SRAM_DO
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_ISSUE = 3'd1;
  localparam logic [2:0] ST_RD_DONE  = 3'd2;
  localparam logic [2:0] ST_WR_WORD  = 3'd3;
  localparam logic [2:0] ST_RMW_RD   = 3'd4;
  localparam logic [2:0] ST_RMW_WR   = 3'd5;

  logic [2:0]    state, state_nxt;
  logic [AW-1:0] addr_q;
  logic [1:0]    lo_q;
  logic [2:0]    size_q;
  logic [31:0]   wdata_q;
  logic [31:0]   hrdata_q;
  logic [3:0]    lane_mask;
  logic [31:0]   lane_bits;
  logic          take;

  // Upper address bits alias away; HTRANS[0] only separates NONSEQ/SEQ.
  logic unused_ok;
  assign unused_ok = ^{HADDR[31:AW+2], HTRANS[0]};

  assign HREADYOUT = !((state == ST_RD_ISSUE) || (state == ST_RMW_RD));
  assign HRESP     = 1'b0;
  assign take      = HSEL & HTRANS[1] & HREADY & HREADYOUT;

  // SRAM_DO is already a registered SRAM output, so it is forwarded during
  // RD_DONE and a captured copy holds the value until the next read.
  assign HRDATA = (state == ST_RD_DONE) ? SRAM_DO : hrdata_q;

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_RD_ISSUE: state_nxt = ST_RD_DONE;
      ST_RMW_RD:   state_nxt = ST_RMW_WR;
      default: begin
        if (take) begin
          if (!HWRITE)          state_nxt = ST_RD_ISSUE;
          else if (HSIZE >= 3'd2) state_nxt = ST_WR_WORD;
          else                  state_nxt = ST_RMW_RD;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      lo_q     <= '0;
      size_q   <= '0;
      wdata_q  <= '0;
      hrdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        addr_q <= HADDR[AW+1:2];
        lo_q   <= HADDR[1:0];
        size_q <= HSIZE;
      end
      if (state == ST_RMW_RD) wdata_q  <= HWDATA;
      if (state == ST_RD_DONE) hrdata_q <= SRAM_DO;
    end
  end

  always_comb begin
    lane_mask = 4'b1111;
    if (size_q == 3'd0)      lane_mask = 4'b0001 << lo_q;
    else if (size_q == 3'd1) lane_mask = lo_q[1] ? 4'b1100 : 4'b0011;
  end

  assign lane_bits = {{8{lane_mask[3]}}, {8{lane_mask[2]}},
                      {8{lane_mask[1]}}, {8{lane_mask[0]}}};

  always_comb begin
    SRAM_CSN  = 1'b1;
    SRAM_WE   = 1'b0;
    SRAM_BE   = '0;
    SRAM_ADDR = '0;
    SRAM_DI   = '0;
    case (state)
      ST_RD_ISSUE, ST_RMW_RD: begin
        SRAM_CSN  = 1'b0;
        SRAM_BE   = 4'hF;
        SRAM_ADDR = addr_q;
      end
      ST_WR_WORD: begin
        SRAM_CSN  = 1'b0;
        SRAM_WE   = 1'b1;
        SRAM_BE   = 4'hF;
        SRAM_ADDR = addr_q;
        SRAM_DI   = HWDATA;
      end
      ST_RMW_WR: begin
        SRAM_CSN  = 1'b0;
        SRAM_WE   = 1'b1;
        SRAM_BE   = 4'hF;
        SRAM_ADDR = addr_q;
        SRAM_DI   = (SRAM_DO & ~lane_bits) | (wdata_q & lane_bits);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_sram_bridge.sv
module tb_ahb_sram_bridge;

  localparam int AW = 12;

  logic          CLK = 1'b0;
  logic          RST;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic [31:0]   HRDATA;
  logic          HRESP;
  logic          SRAM_CSN;
  logic [AW-1:0] SRAM_ADDR;
  logic          SRAM_WE;
  logic [3:0]    SRAM_BE;
  logic [31:0]   SRAM_DI;
  logic [31:0]   SRAM_DO;

  always #5 CLK = ~CLK;

  // Single slave on the bus: its ready is the bus ready.
  assign HREADY = HREADYOUT;

  ahb_sram_bridge #(.AW(AW)) dut (
    .CLK(CLK), .RST(RST), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
    .SRAM_CSN(SRAM_CSN), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE(SRAM_WE),
    .SRAM_BE(SRAM_BE), .SRAM_DI(SRAM_DI), .SRAM_DO(SRAM_DO)
  );

  // Synchronous SRAM model: registered read data, byte-enabled write.
  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] sram_do_r = '0;
  assign SRAM_DO = sram_do_r;
  always @(posedge CLK) begin
    if (SRAM_CSN === 1'b0) begin
      if (SRAM_WE) begin
        for (int i = 0; i < 4; i++)
          if (SRAM_BE[i]) mem[SRAM_ADDR][i*8 +: 8] <= SRAM_DI[i*8 +: 8];
      end else begin
        sram_do_r <= mem[SRAM_ADDR];
      end
    end
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp;
  } xfer_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] di;
  } op_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [0:(1<<AW)-1];
  op_t         op_q[$];
  logic [31:0] rd_q[$];
  logic        mon_en = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  function automatic xfer_t mk(logic wr, logic [31:0] addr, logic [2:0] size,
                               logic [31:0] wdata, logic [31:0] exp);
    xfer_t x;
    x.wr = wr; x.addr = addr; x.size = size; x.wdata = wdata; x.exp = exp;
    return x;
  endfunction

  // Is byte i of the word touched by a transfer of this size/offset?
  function automatic bit touches(int i, logic [2:0] size, logic [1:0] lo);
    if (size >= 3'd2) return 1'b1;
    if (size == 3'd1) return (i / 2) == int'(lo[1]);
    return i == int'(lo);
  endfunction

  // Scoreboard push at acceptance: expected SRAM accesses and read data.
  task automatic expect_xfer(input xfer_t x);
    op_t         op;
    logic [31:0] w;
    logic [31:0] nv;
    w  = {20'd0, x.addr[AW+1:2]};
    op.addr = w;
    op.di   = '0;
    if (!x.wr) begin
      op.we = 1'b0; op_q.push_back(op);
      rd_q.push_back(x.exp);
    end else begin
      nv = ref_mem[w];
      for (int i = 0; i < 4; i++)
        if (touches(i, x.size, x.addr[1:0])) nv[i*8 +: 8] = x.wdata[i*8 +: 8];
      ref_mem[w] = nv;
      if (x.size < 3'd2) begin
        op.we = 1'b0; op_q.push_back(op);
      end
      op.we = 1'b1; op.di = nv; op_q.push_back(op);
    end
  endtask

  task automatic drive_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'd0;
  endtask

  // Pipelined AHB master: next address phase overlaps current data phase.
  task automatic run_xfers(input xfer_t xs[$]);
    int          idx = 0;
    bit          dp_act = 0;
    bit          dp_wr = 0;
    logic [31:0] dp_wd = '0;
    int          waits = 0;
    int          exp_w = 0;
    int          guard = 0;
    logic        rdy;
    while ((idx < xs.size() || dp_act) && guard < 500) begin
      guard++;
      if (idx < xs.size()) begin
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = xs[idx].addr;
        HWRITE = xs[idx].wr; HSIZE = xs[idx].size;
      end else begin
        drive_idle();
      end
      HWDATA = dp_wd;
      @(negedge CLK);
      rdy = HREADYOUT;
      if (dp_act) begin
        if (!rdy) begin
          waits++;
          if (waits > 4) begin
            chk("hreadyout_timeout", 32'(waits), 32'(exp_w));
            drive_idle();
            return;
          end
        end else begin
          chk("wait_states", 32'(waits), 32'(exp_w));
          if (!dp_wr) begin
            if (rd_q.size() == 0) chk("rd_queue_empty", 32'd0, 32'd1);
            else chk("hrdata", HRDATA, rd_q.pop_front());
          end
        end
      end
      @(posedge CLK);
      #1;
      if (rdy) begin
        dp_act = 0;
        if (idx < xs.size()) begin
          dp_act = 1;
          dp_wr  = xs[idx].wr;
          dp_wd  = xs[idx].wdata;
          waits  = 0;
          exp_w  = (!xs[idx].wr || xs[idx].size < 3'd2) ? 1 : 0;
          expect_xfer(xs[idx]);
          idx++;
        end
      end
    end
    drive_idle();
    HWDATA = dp_wd;
    @(posedge CLK);
    #1;
    chk("ops_drained", 32'(op_q.size()), 32'd0);
    chk("reads_drained", 32'(rd_q.size()), 32'd0);
  endtask

  // SRAM-side monitor: every access in order against the scoreboard,
  // idle-bus values when nothing is active, HRESP always OKAY.
  always @(negedge CLK) begin
    if (mon_en) begin
      chk("hresp", HRESP, 1'b0);
      if (SRAM_CSN === 1'b0) begin
        if (op_q.size() == 0) begin
          chk("sram_unexpected_access_we", SRAM_WE, 1'bx);
        end else begin
          op_t op;
          op = op_q.pop_front();
          chk("sram_we", SRAM_WE, op.we);
          chk("sram_addr", 32'(SRAM_ADDR), op.addr);
          chk("sram_be", SRAM_BE, 4'hF);
          if (op.we) chk("sram_di", SRAM_DI, op.di);
        end
      end else begin
        chk("idle_sram_bus", {SRAM_WE, SRAM_BE, 32'(SRAM_ADDR) ^ SRAM_DI}, '0);
      end
    end
  end

  xfer_t vec [17];
  xfer_t q[$];

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    vec[0]  = mk(1, 32'h10,   3'd2, 32'hDEADBEEF, 'x);
    vec[1]  = mk(0, 32'h10,   3'd2, 'x,           32'hDEADBEEF);
    vec[2]  = mk(1, 32'h20,   3'd2, 32'h11223344, 'x);
    vec[3]  = mk(1, 32'h22,   3'd0, 32'h00AA0000, 'x);
    vec[4]  = mk(0, 32'h20,   3'd2, 'x,           32'h11AA3344);
    vec[5]  = mk(1, 32'h30,   3'd2, 32'hCAFEF00D, 'x);
    vec[6]  = mk(1, 32'h31,   3'd1, 32'h00005555, 'x);
    vec[7]  = mk(0, 32'h30,   3'd2, 'x,           32'hCAFE5555);
    vec[8]  = mk(1, 32'h63,   3'd0, 32'h77000000, 'x);
    vec[9]  = mk(1, 32'h61,   3'd0, 32'h00003300, 'x);
    vec[10] = mk(1, 32'h62,   3'd1, 32'hBEEF0000, 'x);
    vec[11] = mk(0, 32'h60,   3'd2, 'x,           32'hBEEF3300);
    vec[12] = mk(1, 32'h70,   3'd2, 32'h12345678, 'x);
    vec[13] = mk(0, 32'h4070, 3'd2, 'x,           32'h12345678);
    vec[14] = mk(1, 32'h76,   3'd3, 32'hA5A5A5A5, 'x);
    vec[15] = mk(0, 32'h75,   3'd2, 'x,           32'hA5A5A5A5);
    vec[16] = mk(0, 32'h10,   3'd0, 'x,           32'hDEADBEEF);

    RST = 1'b1;
    drive_idle();
    HWDATA = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_hreadyout", HREADYOUT, 1'b1);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_csn", SRAM_CSN, 1'b1);
    chk("rst_hresp", HRESP, 1'b0);
    mon_en = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Table of transfers, issued back-to-back.
    q.delete();
    foreach (vec[i]) q.push_back(vec[i]);
    run_xfers(q);

    // Write, read same address, write: no bubbles, read sees new data.
    q.delete();
    q.push_back(mk(1, 32'h40, 3'd2, 32'h00000001, 'x));
    q.push_back(mk(0, 32'h40, 3'd2, 'x,           32'h00000001));
    q.push_back(mk(1, 32'h44, 3'd2, 32'h00000002, 'x));
    q.push_back(mk(0, 32'h44, 3'd2, 'x,           32'h00000002));
    run_xfers(q);

    // Reset during RMW_RD abandons the byte write to 0x50.
    begin
      op_t op;
      op.we = 1'b0; op.addr = 32'h14; op.di = '0;
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h50; HWRITE = 1'b1; HSIZE = 3'd0;
      op_q.push_back(op);
      @(posedge CLK);
      #1;
      drive_idle();
      HWDATA = 32'h000000AB;
      RST = 1'b1;
      @(negedge CLK);
      chk("rmw_rd_hreadyout", HREADYOUT, 1'b0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("rmw_rst_hreadyout", HREADYOUT, 1'b1);
      chk("rmw_rst_hrdata", HRDATA, 32'h0);
      chk("rmw_rst_csn", SRAM_CSN, 1'b1);
      repeat (3) @(posedge CLK);
      #1;
      chk("rmw_rst_mem", mem[12'h14], 32'h0);
      q.delete();
      q.push_back(mk(0, 32'h50, 3'd2, 'x, 32'h0));
      run_xfers(q);
    end

    // Unselected, IDLE and BUSY cycles cause no access.
    for (int p = 0; p < 3; p++) begin
      HSEL   = (p != 0);
      HTRANS = (p == 0) ? 2'b10 : (p == 1) ? 2'b00 : 2'b01;
      HADDR  = 32'h10; HWRITE = 1'b1; HSIZE = 3'd2; HWDATA = 32'hFFFFFFFF;
      for (int c = 0; c < 10; c++) begin
        @(negedge CLK);
        chk("idle_csn", SRAM_CSN, 1'b1);
        chk("idle_hreadyout", HREADYOUT, 1'b1);
        @(posedge CLK);
        #1;
      end
    end
    drive_idle();
    q.delete();
    q.push_back(mk(0, 32'h10, 3'd2, 'x, 32'hDEADBEEF));
    run_xfers(q);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_sram_bridge.md
AHB_SRAM_BRIDGE -- requirements
Module: ahb_sram_bridge

Interface
REQ-001 SHALL have parameter: AW, 12, SRAM word-address width; SRAM depth is 2^AW words.
REQ-002 SHALL have ports, one clock, synchronous active-high reset:
- CLK  in  1  clock; all state updates on posedge
- RST  in  1  synchronous active-high reset
- HSEL  in  1  slave select
- HADDR  in  32  byte address; only HADDR[AW+1:0] used
- HTRANS  in  2  AHB-Lite transfer type
- HWRITE  in  1  1=write
- HSIZE  in  3  0=byte, 1=halfword, 2=word
- HWDATA  in  32  write data, data phase
- HREADY  in  1  bus ready
- HREADYOUT  out  1  slave ready
- HRDATA  out  32  read data
- HRESP  out  1  response; tied 0 (OKAY)
- SRAM_CSN  out  1  SRAM chip select, active low
- SRAM_ADDR  out  AW  SRAM word address
- SRAM_WE  out  1  1=write, 0=read
- SRAM_BE  out  4  byte enables
- SRAM_DI  out  32  SRAM write data
- SRAM_DO  in  32  SRAM read data, valid the cycle after a read is issued

Function
REQ-003 SHALL accept an address phase at a posedge when HSEL & HTRANS[1] & HREADY; SHALL latch word address HADDR[AW+1:2], HADDR[1:0], HSIZE, HWRITE.
REQ-004 SHALL ignore IDLE/BUSY transfers and unselected cycles; state unchanged.
REQ-005 SHALL compute lane mask: byte -> 4'b0001<<HADDR[1:0]; halfword -> 4'b0011 (HADDR[1]=0) or 4'b1100 (HADDR[1]=1), HADDR[0] ignored; HSIZE>=2 -> 4'b1111, HADDR[1:0] ignored.
REQ-006 SHALL implement FSM states IDLE, RD_ISSUE, RD_DONE, WR_WORD, RMW_RD, RMW_WR.
REQ-007 Accepted read -> RD_ISSUE: SRAM_CSN=0, SRAM_WE=0, SRAM_BE=4'hF, SRAM_ADDR=latched; HREADYOUT=0; next RD_DONE.
REQ-008 RD_DONE: HRDATA registered from SRAM_DO (full word, all lanes) and HREADYOUT=1 in same cycle; read = one wait state.
REQ-009 Accepted word write -> WR_WORD: SRAM_CSN=0, SRAM_WE=1, SRAM_BE=4'hF, SRAM_DI=HWDATA; HREADYOUT=1; zero wait states.
REQ-010 Accepted byte/halfword write SHALL use read-modify-write; SRAM never written with BE other than 4'hF.
REQ-011 RMW_RD: issue full-word read as REQ-007, capture HWDATA into a register, HREADYOUT=0; next RMW_WR.
REQ-012 RMW_WR: SRAM_CSN=0, SRAM_WE=1, SRAM_BE=4'hF, SRAM_DI = SRAM_DO with masked lanes replaced by captured HWDATA lanes; HREADYOUT=1.
REQ-013 In any state with HREADYOUT=1 (IDLE, RD_DONE, WR_WORD, RMW_WR) a new address phase SHALL be accepted and the FSM SHALL go directly to its first state (back-to-back, no bubble); else -> IDLE.
REQ-014 Write followed immediately by read of the same address SHALL return the newly written data (write lands at the edge before the read is issued).
REQ-015 When no SRAM access is active: SRAM_CSN=1, SRAM_WE=0, SRAM_BE=0, SRAM_ADDR=0, SRAM_DI=0.
REQ-016 HRDATA SHALL hold its last value until the next RD_DONE; HRESP SHALL be 0 always.
REQ-017 Addresses above 2^(AW+2) bytes SHALL alias (upper bits dropped), no error.

Reset
REQ-018 RST at posedge SHALL force IDLE, HREADYOUT=1, HRDATA=0, captured write data=0, SRAM outputs per REQ-015 in the following cycle.
REQ-019 RST asserted mid-RMW (in RMW_RD) SHALL abandon the transfer; no SRAM write issued.

Verification
REQ-020 Word write 0x0000_0010 <- 0xDEADBEEF, then word read 0x10 -> SRAM_ADDR=4, write zero-wait, read one wait state, HRDATA=0xDEADBEEF.
REQ-021 Word 0x20 = 0x11223344; byte write 0x22 <- HWDATA 0x00AA0000 -> SRAM_BE=4'hF, DI=0x11AA3344; readback 0x11AA3344.
REQ-022 Word 0x30 = 0xCAFEF00D; halfword write 0x31 <- HWDATA 0x00005555 -> lanes 4'b0011, readback 0xCAFE5555.
REQ-023 Back-to-back write 0x40 <- 0x1, read 0x40, write 0x44 <- 0x2 with HREADY honoured -> no idle cycles between, read returns 0x00000001.
REQ-024 RST asserted during RMW_RD of byte write to 0x50 (old 0x0) -> no SRAM_WE=1 cycle, HREADYOUT=1, HRDATA=0, word 0x50 still 0x0.
REQ-025 HSEL=0 or HTRANS=IDLE for 10 cycles -> SRAM_CSN stays 1, HREADYOUT stays 1.
